vga_timing_prog: RTL and testbench
==================================

Name: vga_timing_prog

Overview:
Runtime-programmable VGA/DVI timing generator for the pixel clock domain. It produces sync, data-enable, frame and line strobes and signed screen coordinates. Active area is x>=0, y>=0; blanking uses negative coordinates. A second, early coordinate/strobe set leads the screen outputs by LEAD cycles so fetch pipelines (tile/sprite/framebuffer reads) can run ahead. Timing and polarity are written into staging registers and take effect only at a frame boundary.

Parameters:
COORD_WIDTH, 16, signed coordinate width; must hold -(FP+SYNC+BP) and RES-1 for both axes
H_RES, 640, reset-default active pixels per line
H_FP, 16, reset-default horizontal front porch
H_SYNC, 96, reset-default hsync width
H_BP, 48, reset-default horizontal back porch
V_RES, 480, reset-default active lines
V_FP, 10, reset-default vertical front porch
V_SYNC, 2, reset-default vsync width
V_BP, 33, reset-default vertical back porch
H_POL, 0, reset-default hsync polarity (1 = active-high)
V_POL, 0, reset-default vsync polarity
LEAD, 2, cycles by which fetch_* lead the screen outputs; range 0..15

Ports:
clk_pixel  in  1  pixel clock
rst_pixel  in  1  asynchronous, active-high reset
cfg_we  in  1  write cfg_data into staging register cfg_addr
cfg_addr  in  4  0 H_RES, 1 H_FP, 2 H_SYNC, 3 H_BP, 4 V_RES, 5 V_FP, 6 V_SYNC, 7 V_BP, 8 polarity (bit0 H, bit1 V); 9-15 ignored
cfg_data  in  COORD_WIDTH  unsigned write value
cfg_commit  in  1  request staging to active transfer at the next frame boundary
cfg_pending  out  1  commit requested, not yet applied
fetch_x, fetch_y  out  COORD_WIDTH each  early signed coordinates
fetch_de, fetch_frame, fetch_line  out  1 each  early strobes
hsync, vsync  out  1 each  sync outputs at the configured polarity
data_enable, frame, line  out  1 each  screen-aligned strobes
screen_x, screen_y  out  COORD_WIDTH each  screen-aligned signed coordinates

Behaviour:
- Active set A: H_START=-(FP+SYNC+BP), HS_START=H_START+FP, HS_END=HS_START+SYNC, HA_END=RES-1. The vertical axis uses the same formulas.
- Counter: x increments each cycle. At x==HA_END, x goes to H_START and y increments. At y==VA_END, y wraps to V_START.
- Stage 0 outputs are registered from the counter state (1-cycle latency) and drive fetch_*:
  - de = (x>=0 && y>=0)
  - frame = (x==H_START && y==V_START)
  - line = (x==H_START && y>=0)
  - sync active while HS_START<=x<HS_END (horizontal) or VS_START<=y<VS_END (vertical), output level set by the polarity in force for that counter state.
- hsync/vsync/data_enable/frame/line/screen_x/screen_y equal stage 0 delayed LEAD cycles through a register pipeline. With LEAD=0 they equal stage 0.
- Staging: cfg_we writes one register per cycle. Out-of-range addresses are ignored. Only bits [1:0] of address 8 are stored.
- Commit:
  - cfg_commit sets cfg_pending.
  - Boundary cycle = the cycle with x==HA_END && y==VA_END and cfg_pending set (or cfg_commit asserted in that same cycle). On it: A <= staging, the counter loads the new H_START/V_START, and cfg_pending clears.
  - A cfg_we in the boundary cycle is included in the transfer.
  - Writes while pending update staging and are included.
- Field constraints: RES>=1 required; a zero FP, SYNC or BP is legal. SYNC=0 gives no pulse.
- Reset (asynchronous assert, takes effect with no clock edge):
  - staging and A load the parameter defaults; counter = (H_START, V_START) of the defaults; cfg_pending=0.
  - All pipeline stages: de=frame=line=0, x=y=0, sync at inactive level (~POL default).
- Reset mid-frame abandons any pending commit.

Test Plan:
- Bench params: H_RES=8, H_FP=1, H_SYNC=2, H_BP=1, V_RES=4, V_FP=1, V_SYNC=1, V_BP=1, LEAD=2. This gives H_START=-4, 12-cycle line, 7 lines, 84-cycle frame.
- Reset release -> fetch_frame=1 on the first edge after deassert, frame=1 two cycles later. Both repeat every 84 cycles. screen_x/screen_y step -4..7 / -3..3.
- Sync, POL=0 -> hsync low exactly while screen_x in {-3,-2}, 2 of every 12 cycles. vsync low exactly while screen_y==-2, 12 cycles per frame.
- Active area -> data_enable high 8 cycles per line on 4 lines, 32 per frame, with screen_x 0..7. line pulses 4 times per frame at screen_x==-4. Each fetch_* matches its screen counterpart 2 cycles earlier.
- Mid-frame reconfiguration: cfg_we addr0=16, then cfg_commit -> cfg_pending=1 until the boundary and the current frame keeps 12-cycle lines. The next frame has 20-cycle lines, 140-cycle frame, data_enable 16 per line.
- Commit in the boundary cycle: cfg_we addr8=3 together with cfg_commit at x==7, y==3 -> applied immediately. cfg_pending never observed high, and syncs are active-high from the next frame.
- Asynchronous rst_pixel pulse mid-line between clock edges -> outputs take reset values immediately, cfg_pending=0, defaults restored. After release, the default 84-cycle frame resumes from (-4,-3).

Source files
------------

// File: rtl/vga_timing_prog.sv
// vga_timing_prog: runtime-programmable VGA/DVI timing generator.
// The fetch_* outputs lead the screen-aligned outputs by LEAD cycles.
// New timing and polarity values are staged and only applied at a frame boundary.
module vga_timing_prog #(
    parameter int unsigned COORD_WIDTH = 16,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned H_POL       = 0,
    parameter int unsigned V_POL       = 0,
    parameter int unsigned LEAD        = 2
) (
    input  logic                          clk_pixel,
    input  logic                          rst_pixel,
    input  logic                          cfg_we,
    input  logic [3:0]                    cfg_addr,
    input  logic [COORD_WIDTH-1:0]        cfg_data,
    input  logic                          cfg_commit,
    output logic                          cfg_pending,
    output logic signed [COORD_WIDTH-1:0] fetch_x,
    output logic signed [COORD_WIDTH-1:0] fetch_y,
    output logic                          fetch_de,
    output logic                          fetch_frame,
    output logic                          fetch_line,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          data_enable,
    output logic                          frame,
    output logic                          line,
    output logic signed [COORD_WIDTH-1:0] screen_x,
    output logic signed [COORD_WIDTH-1:0] screen_y
);
    localparam int unsigned CW = COORD_WIDTH;

    typedef logic [CW-1:0]        field_t;
    typedef logic signed [CW-1:0] coord_t;

    // One complete timing set; pol[0] = hsync active level, pol[1] = vsync active level.
    typedef struct packed {
        field_t     h_res;
        field_t     h_fp;
        field_t     h_sync;
        field_t     h_bp;
        field_t     v_res;
        field_t     v_fp;
        field_t     v_sync;
        field_t     v_bp;
        logic [1:0] pol;
    } timing_t;

    // One pixel's worth of timing outputs, carried down the lead pipeline.
    typedef struct packed {
        field_t x;
        field_t y;
        logic   de;
        logic   frame;
        logic   line;
        logic   hs;
        logic   vs;
    } pix_t;

    // First blanking coordinate of an axis: -(fp + sync + bp), wrapped to CW bits.
    function automatic coord_t blank_start(input field_t fp, input field_t sync, input field_t bp);
        return coord_t'(field_t'(0) - fp - sync - bp);
    endfunction

    localparam timing_t DEFAULTS = '{
        h_res:  field_t'(H_RES),
        h_fp:   field_t'(H_FP),
        h_sync: field_t'(H_SYNC),
        h_bp:   field_t'(H_BP),
        v_res:  field_t'(V_RES),
        v_fp:   field_t'(V_FP),
        v_sync: field_t'(V_SYNC),
        v_bp:   field_t'(V_BP),
        pol:    {1'(V_POL), 1'(H_POL)}
    };

    localparam coord_t DEF_H_START = blank_start(field_t'(H_FP), field_t'(H_SYNC), field_t'(H_BP));
    localparam coord_t DEF_V_START = blank_start(field_t'(V_FP), field_t'(V_SYNC), field_t'(V_BP));

    localparam pix_t PIX_RST = '{
        x:     '0,
        y:     '0,
        de:    1'b0,
        frame: 1'b0,
        line:  1'b0,
        hs:    ~1'(H_POL),
        vs:    ~1'(V_POL)
    };

    timing_t act_q;
    timing_t stg_q;
    timing_t stg_d;
    coord_t  x_q;
    coord_t  y_q;
    coord_t  h_start;
    coord_t  hs_start;
    coord_t  hs_end;
    coord_t  ha_end;
    coord_t  v_start;
    coord_t  vs_start;
    coord_t  vs_end;
    coord_t  va_end;
    coord_t  nh_start;
    coord_t  nv_start;
    logic    at_end;
    logic    boundary;
    pix_t    s0_d;
    pix_t    s0_q;
    pix_t    scr;

    // Axis landmarks of the active set, plus start points of the staged set for a commit.
    always_comb begin
        h_start  = blank_start(act_q.h_fp, act_q.h_sync, act_q.h_bp);
        hs_start = h_start + coord_t'(act_q.h_fp);
        hs_end   = hs_start + coord_t'(act_q.h_sync);
        ha_end   = coord_t'(act_q.h_res - field_t'(1));
        v_start  = blank_start(act_q.v_fp, act_q.v_sync, act_q.v_bp);
        vs_start = v_start + coord_t'(act_q.v_fp);
        vs_end   = vs_start + coord_t'(act_q.v_sync);
        va_end   = coord_t'(act_q.v_res - field_t'(1));
        nh_start = blank_start(stg_d.h_fp, stg_d.h_sync, stg_d.h_bp);
        nv_start = blank_start(stg_d.v_fp, stg_d.v_sync, stg_d.v_bp);
        at_end   = (x_q == ha_end) && (y_q == va_end);
        boundary = at_end && (cfg_pending || cfg_commit);
    end

    // Staging contents after this cycle's write, so a same-cycle write joins a commit.
    always_comb begin
        stg_d = stg_q;
        if (cfg_we) begin
            case (cfg_addr)
                4'd0:    stg_d.h_res  = cfg_data;
                4'd1:    stg_d.h_fp   = cfg_data;
                4'd2:    stg_d.h_sync = cfg_data;
                4'd3:    stg_d.h_bp   = cfg_data;
                4'd4:    stg_d.v_res  = cfg_data;
                4'd5:    stg_d.v_fp   = cfg_data;
                4'd6:    stg_d.v_sync = cfg_data;
                4'd7:    stg_d.v_bp   = cfg_data;
                4'd8:    stg_d.pol    = cfg_data[1:0];
                default: stg_d = stg_q;
            endcase
        end
    end

    // Staging/active registers, commit handshake and the raster counter.
    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            stg_q       <= DEFAULTS;
            act_q       <= DEFAULTS;
            x_q         <= DEF_H_START;
            y_q         <= DEF_V_START;
            cfg_pending <= 1'b0;
        end else begin
            stg_q <= stg_d;
            if (boundary) begin
                act_q       <= stg_d;
                x_q         <= nh_start;
                y_q         <= nv_start;
                cfg_pending <= 1'b0;
            end else begin
                if (cfg_commit) begin
                    cfg_pending <= 1'b1;
                end
                if (x_q == ha_end) begin
                    x_q <= h_start;
                    y_q <= (y_q == va_end) ? v_start : y_q + coord_t'(1);
                end else begin
                    x_q <= x_q + coord_t'(1);
                end
            end
        end
    end

    // Stage 0 decode of the current counter state under the active set.
    always_comb begin
        s0_d       = PIX_RST;
        s0_d.x     = field_t'(x_q);
        s0_d.y     = field_t'(y_q);
        s0_d.de    = ~x_q[CW-1] & ~y_q[CW-1];
        s0_d.frame = (x_q == h_start) && (y_q == v_start);
        s0_d.line  = (x_q == h_start) && ~y_q[CW-1];
        s0_d.hs    = ((x_q >= hs_start) && (x_q < hs_end)) ? act_q.pol[0] : ~act_q.pol[0];
        s0_d.vs    = ((y_q >= vs_start) && (y_q < vs_end)) ? act_q.pol[1] : ~act_q.pol[1];
    end

    // Stage 0 register feeding the fetch outputs.
    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            s0_q <= PIX_RST;
        end else begin
            s0_q <= s0_d;
        end
    end

    generate
        if (LEAD == 0) begin : g_no_lead
            assign scr = s0_q;
        end else begin : g_lead
            pix_t dly_q [LEAD];

            // Delay line that lets fetch_* run LEAD cycles ahead of the screen outputs.
            always_ff @(posedge clk_pixel or posedge rst_pixel) begin
                if (rst_pixel) begin
                    for (int i = 0; i < int'(LEAD); i++) begin
                        dly_q[i] <= PIX_RST;
                    end
                end else begin
                    dly_q[0] <= s0_q;
                    for (int i = 1; i < int'(LEAD); i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign scr = dly_q[LEAD-1];
        end
    endgenerate

    assign fetch_x     = coord_t'(s0_q.x);
    assign fetch_y     = coord_t'(s0_q.y);
    assign fetch_de    = s0_q.de;
    assign fetch_frame = s0_q.frame;
    assign fetch_line  = s0_q.line;

    assign screen_x    = coord_t'(scr.x);
    assign screen_y    = coord_t'(scr.y);
    assign data_enable = scr.de;
    assign frame       = scr.frame;
    assign line        = scr.line;
    assign hsync       = scr.hs;
    assign vsync       = scr.vs;

endmodule

// File: tb/tb_vga_timing_prog.sv
// tb_vga_timing_prog: directed and randomized checks of vga_timing_prog against a frame-position model.
module tb_vga_timing_prog;
    localparam int unsigned CW   = 16;
    localparam int unsigned LEAD = 2;
    localparam int DEF [9] = '{8, 1, 2, 1, 4, 1, 1, 1, 0};

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          de;
        logic          frame;
        logic          line;
        logic          hs;
        logic          vs;
    } obs_t;

    logic                 clk_pixel;
    logic                 rst_pixel;
    logic                 cfg_we;
    logic [3:0]           cfg_addr;
    logic [CW-1:0]        cfg_data;
    logic                 cfg_commit;
    logic                 cfg_pending;
    logic signed [CW-1:0] fetch_x;
    logic signed [CW-1:0] fetch_y;
    logic                 fetch_de;
    logic                 fetch_frame;
    logic                 fetch_line;
    logic                 hsync;
    logic                 vsync;
    logic                 data_enable;
    logic                 frame;
    logic                 line;
    logic signed [CW-1:0] screen_x;
    logic signed [CW-1:0] screen_y;

    int   nchk;
    int   nbad;
    int   m_act [9];
    int   m_stg [9];
    int   m_pos;
    bit   m_pend;
    obs_t hist [$];

    vga_timing_prog #(
        .COORD_WIDTH(CW),
        .H_RES(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(0), .V_POL(0),
        .LEAD(LEAD)
    ) dut (
        .clk_pixel(clk_pixel),
        .rst_pixel(rst_pixel),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cfg_commit(cfg_commit),
        .cfg_pending(cfg_pending),
        .fetch_x(fetch_x),
        .fetch_y(fetch_y),
        .fetch_de(fetch_de),
        .fetch_frame(fetch_frame),
        .fetch_line(fetch_line),
        .hsync(hsync),
        .vsync(vsync),
        .data_enable(data_enable),
        .frame(frame),
        .line(line),
        .screen_x(screen_x),
        .screen_y(screen_y)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Frame length in cycles: whole lines times whole line count.
    function automatic int flen(input int c [9]);
        return (c[0] + c[1] + c[2] + c[3]) * (c[4] + c[5] + c[6] + c[7]);
    endfunction

    // Expected outputs for frame position pos: row-major scan starting at blanking origin.
    function automatic obs_t model_out(input int pos, input int c [9]);
        obs_t o;
        int hblank, vblank, ht, hx, vy, xs, ys;
        hblank  = c[1] + c[2] + c[3];
        vblank  = c[5] + c[6] + c[7];
        ht      = c[0] + hblank;
        hx      = pos % ht;
        vy      = pos / ht;
        xs      = hx - hblank;
        ys      = vy - vblank;
        o.x     = CW'(xs);
        o.y     = CW'(ys);
        o.de    = (xs >= 0) && (ys >= 0);
        o.frame = (pos == 0);
        o.line  = (hx == 0) && (ys >= 0);
        o.hs    = (hx >= c[1] && hx < c[1] + c[2]) ? 1'(c[8]) : ~1'(c[8]);
        o.vs    = (vy >= c[5] && vy < c[5] + c[6]) ? 1'(c[8] >> 1) : ~1'(c[8] >> 1);
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic obs_t strip_sync(input obs_t o);
        obs_t r;
        r = o;
        r.hs = 1'b0;
        r.vs = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_act[i] = DEF[i];
            m_stg[i] = DEF[i];
        end
        m_pos  = 0;
        m_pend = 1'b0;
        hist.delete();
        for (int i = 0; i <= int'(LEAD); i++) hist.push_back(reset_obs());
    endtask

    // Advance the model by one clock edge with the inputs present at that edge.
    task automatic model_edge(input logic we, input logic [3:0] a, input logic [CW-1:0] d, input logic commit);
        int  len;
        bit  last;
        hist.push_back(model_out(m_pos, m_act));
        void'(hist.pop_front());
        len  = flen(m_act);
        last = (m_pos == len - 1);
        if (we && a <= 4'd8) m_stg[a] = (a == 4'd8) ? int'(d[1:0]) : int'(d);
        if (last && (m_pend || commit)) begin
            m_act  = m_stg;
            m_pos  = 0;
            m_pend = 1'b0;
        end else begin
            if (commit) m_pend = 1'b1;
            m_pos = (m_pos + 1) % len;
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        nchk++;
        assert (got === exp) else begin
            nbad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t got, input obs_t exp);
        nchk++;
        assert (got === exp) else begin
            nbad++;
            $error("FAIL %s observed x=%0d y=%0d de=%b fr=%b ln=%b hs=%b vs=%b expected x=%0d y=%0d de=%b fr=%b ln=%b hs=%b vs=%b",
                   tag, $signed(got.x), $signed(got.y), got.de, got.frame, got.line, got.hs, got.vs,
                   $signed(exp.x), $signed(exp.y), exp.de, exp.frame, exp.line, exp.hs, exp.vs);
        end
    endtask

    task automatic check_outputs();
        obs_t af, as_;
        af  = '{x: fetch_x, y: fetch_y, de: fetch_de, frame: fetch_frame, line: fetch_line, hs: 1'b0, vs: 1'b0};
        as_ = '{x: screen_x, y: screen_y, de: data_enable, frame: frame, line: line, hs: hsync, vs: vsync};
        chk_obs("fetch", af, strip_sync(hist[LEAD]));
        chk_obs("screen", as_, hist[0]);
        chk_int("pending", int'(cfg_pending), int'(m_pend));
    endtask

    // One clock with the given inputs; called and returning at a falling edge.
    task automatic cycle(input logic we, input logic [3:0] a, input logic [CW-1:0] d, input logic commit);
        cfg_we     = we;
        cfg_addr   = a;
        cfg_data   = d;
        cfg_commit = commit;
        @(posedge clk_pixel);
        model_edge(we, a, d, commit);
        @(negedge clk_pixel);
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        check_outputs();
    endtask

    // Measure one screen frame from a frame pulse to the next.
    task automatic frame_stats(input logic lvl, input int hres,
                               output int len, output int de_n, output int line_n,
                               output int hs_n, output int vs_n, output int de_bad);
        int guard;
        len = 0; de_n = 0; line_n = 0; hs_n = 0; vs_n = 0; de_bad = 0; guard = 0;
        while (frame !== 1'b1 && guard < 1000) begin
            cycle(1'b0, 4'd0, '0, 1'b0);
            guard++;
        end
        chk_int("frame_wait", int'(frame), 1);
        do begin
            len++;
            if (data_enable) de_n++;
            if (data_enable && (int'(screen_x) < 0 || int'(screen_x) >= hres)) de_bad++;
            if (line) line_n++;
            if (hsync === lvl) hs_n++;
            if (vsync === lvl) vs_n++;
            cycle(1'b0, 4'd0, '0, 1'b0);
        end while (frame !== 1'b1 && len < 1000);
    endtask

    task automatic async_reset();
        #2 rst_pixel = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (3) @(negedge clk_pixel);
        rst_pixel = 1'b0;
    endtask

    initial begin
        int len, de_n, line_n, hs_n, vs_n, de_bad, guard;
        logic [3:0]    ra;
        logic [CW-1:0] rd;
        nchk = 0;
        nbad = 0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        rst_pixel = 1'b0;
        #1 rst_pixel = 1'b1;
        #2;
        model_reset();
        check_outputs();
        repeat (2) @(negedge clk_pixel);
        rst_pixel = 1'b0;

        // First edge after release decodes the frame origin.
        cycle(1'b0, 4'd0, '0, 1'b0);
        chk_int("first_fetch_frame", int'(fetch_frame), 1);
        chk_int("first_fetch_x", int'(fetch_x), -4);
        chk_int("first_fetch_y", int'(fetch_y), -3);

        // Default frame statistics.
        frame_stats(1'b0, 8, len, de_n, line_n, hs_n, vs_n, de_bad);
        chk_int("def_len", len, 84);
        chk_int("def_de", de_n, 32);
        chk_int("def_line", line_n, 4);
        chk_int("def_hs_low", hs_n, 14);
        chk_int("def_vs_low", vs_n, 12);
        chk_int("def_de_range", de_bad, 0);

        // Mid-frame reconfiguration to 16 active pixels.
        repeat (30) cycle(1'b0, 4'd0, '0, 1'b0);
        cycle(1'b1, 4'd0, 16'd16, 1'b0);
        cycle(1'b0, 4'd0, '0, 1'b1);
        chk_int("cfg_pending_set", int'(cfg_pending), 1);
        frame_stats(1'b0, 16, len, de_n, line_n, hs_n, vs_n, de_bad);
        chk_int("wide_len", len, 140);
        chk_int("wide_de", de_n, 64);
        chk_int("wide_line", line_n, 4);
        chk_int("wide_hs_low", hs_n, 14);
        chk_int("wide_vs_low", vs_n, 20);
        chk_int("wide_de_range", de_bad, 0);

        // Pending commit abandoned by an asynchronous reset mid-line.
        repeat (5) cycle(1'b0, 4'd0, '0, 1'b0);
        cycle(1'b1, 4'd0, 16'd12, 1'b0);
        cycle(1'b0, 4'd0, '0, 1'b1);
        chk_int("pending_before_rst", int'(cfg_pending), 1);
        async_reset();
        cycle(1'b0, 4'd0, '0, 1'b0);
        chk_int("resume_x", int'(fetch_x), -4);
        chk_int("resume_y", int'(fetch_y), -3);
        frame_stats(1'b0, 8, len, de_n, line_n, hs_n, vs_n, de_bad);
        chk_int("resume_len", len, 84);
        chk_int("resume_de", de_n, 32);

        // Polarity write plus commit in the boundary cycle itself.
        guard = 0;
        while (m_pos != flen(m_act) - 1 && guard < 500) begin
            cycle(1'b0, 4'd0, '0, 1'b0);
            guard++;
        end
        cycle(1'b1, 4'd8, 16'd3, 1'b1);
        chk_int("bnd_pending", int'(cfg_pending), 0);
        frame_stats(1'b1, 8, len, de_n, line_n, hs_n, vs_n, de_bad);
        chk_int("pol_len", len, 84);
        chk_int("pol_hs_high", hs_n, 14);
        chk_int("pol_vs_high", vs_n, 12);
        chk_int("pol_de", de_n, 32);

        // Random writes and commits against the model.
        for (int n = 0; n < 1500; n++) begin
            ra = 4'($urandom_range(0, 15));
            if (ra == 4'd0 || ra == 4'd4) rd = CW'($urandom_range(1, 6));
            else if (ra == 4'd8 || ra > 4'd8) rd = CW'($urandom);
            else rd = CW'($urandom_range(0, 3));
            cycle(($urandom_range(0, 7) == 0), ra, rd, ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end
endmodule
